// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Control and hazard unit for a 5-stage RV32I pipeline.
//
// The ID-stage opcode is decoded into control bits. The bits then travel
// through the ID/EX, EX/MEM and MEM/WB registers.
//
// Hazard handling:
//   - Load-use hazards always stall.
//   - With FORWARDING = 0, any RAW hazard against EX or MEM stalls.
//   - A taken branch or a jump in EX squashes the wrong-path instructions.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   id_*                   ID-stage instruction fields and valid flag
//   ex_branch_taken        branch comparison result from the EX datapath
//   stall_if, flush_if_id  front-end hold and squash (combinational)
//   illegal_instr          valid ID instruction with an undecodable opcode
//   ex_*                   EX-stage control (registered)
//   forward_a/b            EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   mem_*, wb_*            MEM- and WB-stage control (registered)
//   ex_rd, mem_rd, wb_rd   destination register per stage
module ctrl_pipeline #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          FORWARDING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  flush_if_id,
    output logic                  illegal_instr,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_branch_geq,
    output logic                  ex_jump,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_sel,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       branch_geq;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // A write to x0 is never a hazard or forwarding source.
    function automatic logic src_match(input logic wr_en, input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] rs, input logic used);
        return used && wr_en && (rd != '0) && (rd == rs);
    endfunction

    // EX/MEM has priority because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic mem_wr, input logic [REG_ADDR_W-1:0] m_rd,
                                           input logic wb_wr, input logic [REG_ADDR_W-1:0] w_rd);
        if (src_match(mem_wr, m_rd, rs, 1'b1)) begin
            return 2'b10;
        end else if (src_match(wb_wr, w_rd, rs, 1'b1)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    ctrl_t                 dec_s, ex_ctrl_d, ex_ctrl_q;
    logic                  legal_s, rs1_used_s, rs2_used_s;
    logic                  load_use_s, raw_s, redirect_s, bubble_s, stall_s, illegal_s;
    logic [1:0]            fwd_a_s, fwd_b_s;
    logic [REG_ADDR_W-1:0] ex_rd_d, ex_rd_q, ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q;
    logic                  mem_read_d, mem_read_q, mem_write_d, mem_write_q;
    logic                  mem_reg_write_d, mem_reg_write_q;
    logic [1:0]            mem_wb_sel_d, mem_wb_sel_q;
    logic [REG_ADDR_W-1:0] mem_rd_d, mem_rd_q;
    logic                  wb_reg_write_d, wb_reg_write_q;
    logic [1:0]            wb_sel_d, wb_sel_q;
    logic [REG_ADDR_W-1:0] wb_rd_d, wb_rd_q;

    // ID decode: unknown opcodes and invalid slots produce an all-zero bubble.
    always_comb begin
        dec_s      = BUBBLE;
        legal_s    = 1'b0;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        if (id_valid) begin
            legal_s    = 1'b1;
            rs1_used_s = 1'b1;
            case (id_opcode)
                OP_R: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_op    = 2'b10;
                    rs2_used_s      = 1'b1;
                end
                OP_LOAD: begin
                    dec_s.alu_src   = 1'b1;
                    dec_s.mem_read  = 1'b1;
                    dec_s.reg_write = 1'b1;
                    dec_s.wb_sel    = 2'b01;
                end
                OP_STORE: begin
                    dec_s.alu_src   = 1'b1;
                    dec_s.mem_write = 1'b1;
                    rs2_used_s      = 1'b1;
                end
                OP_BRANCH: begin
                    dec_s.branch     = 1'b1;
                    dec_s.alu_op     = 2'b01;
                    dec_s.branch_geq = id_funct3[2];
                    rs2_used_s       = 1'b1;
                end
                OP_IMM: begin
                    dec_s.alu_src   = 1'b1;
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_op    = 2'b11;
                end
                OP_JAL: begin
                    dec_s.jump      = 1'b1;
                    dec_s.reg_write = 1'b1;
                    dec_s.wb_sel    = 2'b10;
                    rs1_used_s      = 1'b0;
                end
                default: begin
                    legal_s    = 1'b0;
                    rs1_used_s = 1'b0;
                end
            endcase
        end else begin
            legal_s = 1'b0;
        end
    end

    // Hazard detection and redirect.
    // A redirect overrides a stall because the stalled instruction is on the wrong path anyway.
    always_comb begin
        load_use_s = src_match(ex_ctrl_q.mem_read, ex_rd_q, id_rs1, rs1_used_s) |
                     src_match(ex_ctrl_q.mem_read, ex_rd_q, id_rs2, rs2_used_s);
        if (FORWARDING) begin
            raw_s = 1'b0;
        end else begin
            raw_s = src_match(ex_ctrl_q.reg_write, ex_rd_q,  id_rs1, rs1_used_s) |
                    src_match(ex_ctrl_q.reg_write, ex_rd_q,  id_rs2, rs2_used_s) |
                    src_match(mem_reg_write_q,     mem_rd_q, id_rs1, rs1_used_s) |
                    src_match(mem_reg_write_q,     mem_rd_q, id_rs2, rs2_used_s);
        end
        redirect_s = (ex_ctrl_q.branch & ex_branch_taken) | ex_ctrl_q.jump;
        stall_s    = (load_use_s | raw_s) & ~redirect_s;
        bubble_s   = load_use_s | raw_s | redirect_s;
        // Gated by rst_n so that every output reads 0 while reset is held.
        illegal_s  = rst_n & id_valid & ~legal_s;
    end

    // EX operand forwarding selects (tied to regfile without forwarding).
    always_comb begin
        if (FORWARDING) begin
            fwd_a_s = fwd_sel(ex_rs1_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);
            fwd_b_s = fwd_sel(ex_rs2_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // Next-state computation for all three pipeline registers.
    always_comb begin
        if (bubble_s) begin
            ex_ctrl_d = BUBBLE;
            ex_rd_d   = '0;
            ex_rs1_d  = '0;
            ex_rs2_d  = '0;
        end else begin
            ex_ctrl_d = dec_s;
            ex_rd_d   = legal_s ? id_rd : '0;
            // Unused sources are zeroed so that they can never select a forward.
            ex_rs1_d  = rs1_used_s ? id_rs1 : '0;
            ex_rs2_d  = rs2_used_s ? id_rs2 : '0;
        end
        mem_read_d      = ex_ctrl_q.mem_read;
        mem_write_d     = ex_ctrl_q.mem_write;
        mem_reg_write_d = ex_ctrl_q.reg_write;
        mem_wb_sel_d    = ex_ctrl_q.wb_sel;
        mem_rd_d        = ex_rd_q;
        wb_reg_write_d  = mem_reg_write_q;
        wb_sel_d        = mem_wb_sel_q;
        wb_rd_d         = mem_rd_q;
    end

    // Pipeline registers; reset returns every stage to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q       <= BUBBLE;
            ex_rd_q         <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_wb_sel_q    <= 2'b00;
            mem_rd_q        <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_sel_q        <= 2'b00;
            wb_rd_q         <= '0;
        end else begin
            ex_ctrl_q       <= ex_ctrl_d;
            ex_rd_q         <= ex_rd_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_wb_sel_q    <= mem_wb_sel_d;
            mem_rd_q        <= mem_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_sel_q        <= wb_sel_d;
            wb_rd_q         <= wb_rd_d;
        end
    end

    assign stall_if      = stall_s;
    assign flush_if_id   = redirect_s;
    assign illegal_instr = illegal_s;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_branch_geq = ex_ctrl_q.branch_geq;
    assign ex_jump       = ex_ctrl_q.jump;
    assign forward_a     = fwd_a_s;
    assign forward_b     = fwd_b_s;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_sel        = wb_sel_q;
    assign ex_rd         = ex_rd_q;
    assign mem_rd        = mem_rd_q;
    assign wb_rd         = wb_rd_q;

endmodule
